// File: rtl/channel_merge_wrr.sv
`default_nettype none
// ============================================================================
//  Module      : channel_merge_wrr
//  Description : N-to-1 request merger for one memory channel. Round-robin
//                arbitration with bounded burst locking feeds a FWFT queue
//                whose head is offered downstream under valid/grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module channel_merge_wrr #(
    parameter int NUM_PORTS = 4,
    parameter int REQ_WIDTH = 64,
    parameter int LOG_DEPTH = 3,
    parameter int BURST_MAX = 4,
    localparam int SRC_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           in_valid,
    input  logic [NUM_PORTS*REQ_WIDTH-1:0] in_data,
    output logic [NUM_PORTS-1:0]           in_grant,
    output logic                           out_valid,
    output logic [REQ_WIDTH-1:0]           out_data,
    output logic [SRC_W-1:0]               out_src,
    input  logic                           out_grant,
    output logic [LOG_DEPTH:0]             occupancy
);

    localparam int                 CNT_W       = $clog2(BURST_MAX + 1);
    localparam int                 DEPTH       = 1 << LOG_DEPTH;
    localparam logic [LOG_DEPTH:0] C_FULL      = {1'b1, {LOG_DEPTH{1'b0}}};
    localparam logic [CNT_W-1:0]   C_BURST_MAX = CNT_W'(BURST_MAX);
    localparam logic [SRC_W-1:0]   C_LAST_RST  = SRC_W'(NUM_PORTS - 1);

    // Arbitration state
    logic [SRC_W-1:0]     r_last;
    logic [CNT_W-1:0]     r_burst;

    // Queue state
    logic [REQ_WIDTH-1:0] r_mem_data [DEPTH];
    logic [SRC_W-1:0]     r_mem_src  [DEPTH];
    logic [LOG_DEPTH-1:0] r_wptr;
    logic [LOG_DEPTH-1:0] r_rptr;
    logic [LOG_DEPTH:0]   r_count;

    // Combinational signals
    logic [REQ_WIDTH-1:0] w_port_data [NUM_PORTS];
    logic                 w_full;
    logic                 w_empty;
    logic                 w_any;
    logic [SRC_W-1:0]     w_sel;
    logic [SRC_W-1:0]     w_cand;
    logic                 w_enq;
    logic                 w_deq;

    // Split the flat payload bus into per-port words
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign w_port_data[g] = in_data[g*REQ_WIDTH +: REQ_WIDTH];
    end

    assign w_full  = (r_count == C_FULL);
    assign w_empty = (r_count == '0);

    // Grant selection: locked port first, else cyclic scan starting after last
    always_comb begin
        w_any  = 1'b0;
        w_sel  = '0;
        w_cand = '0;
        if (!w_full) begin
            if ((r_burst != '0) && (r_burst < C_BURST_MAX) && in_valid[r_last]) begin
                w_any = 1'b1;
                w_sel = r_last;
            end else begin
                for (int k = 1; k <= NUM_PORTS; k++) begin
                    w_cand = SRC_W'((int'(r_last) + k) % NUM_PORTS);
                    if (!w_any && in_valid[w_cand]) begin
                        w_any = 1'b1;
                        w_sel = w_cand;
                    end
                end
            end
        end
    end

    assign in_grant = w_any ? (NUM_PORTS'(1) << w_sel) : '0;
    assign w_enq    = w_any;
    assign w_deq    = !w_empty && out_grant;

    // Burst/last bookkeeping; everything is frozen while the queue is full
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last  <= C_LAST_RST;
            r_burst <= '0;
        end else if (w_any) begin
            if ((w_sel == r_last) && (r_burst != '0)) begin
                if (r_burst != C_BURST_MAX) begin
                    r_burst <= r_burst + CNT_W'(1);
                end
            end else begin
                r_last  <= w_sel;
                r_burst <= CNT_W'(1);
            end
        end else if (!w_full) begin
            r_burst <= '0;
        end
    end

    // Queue storage; no reset needed since pointers qualify every read
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem_data[r_wptr] <= w_port_data[w_sel];
            r_mem_src[r_wptr]  <= w_sel;
        end
    end

    // Queue pointers and occupancy counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_wptr <= r_wptr + LOG_DEPTH'(1);
            end
            if (w_deq) begin
                r_rptr <= r_rptr + LOG_DEPTH'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + (LOG_DEPTH+1)'(1);
                2'b01:   r_count <= r_count - (LOG_DEPTH+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head is read straight from storage and forced to zero when empty
    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : r_mem_data[r_rptr];
    assign out_src   = w_empty ? '0 : r_mem_src[r_rptr];
    assign occupancy = r_count;

endmodule
`default_nettype wire

// File: tb/tb_channel_merge_wrr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_channel_merge_wrr
//  Description : Self-checking bench for channel_merge_wrr: table-driven
//                arbitration/fill vectors plus FIFO-wrap, reset and
//                pure round-robin sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_channel_merge_wrr;

    localparam int NP = 4;
    localparam int RW = 16;
    localparam int LD = 2;

    logic            clk;
    logic            rst;
    logic [NP-1:0]   in_valid;
    logic [NP*RW-1:0] in_data;
    logic [NP-1:0]   in_grant;
    logic            out_valid;
    logic [RW-1:0]   out_data;
    logic [1:0]      out_src;
    logic            out_grant;
    logic [LD:0]     occupancy;

    logic [NP-1:0]    rr_valid;
    logic [NP*RW-1:0] rr_data;
    logic [NP-1:0]    rr_grant;
    logic             rr_ovalid;
    logic [RW-1:0]    rr_odata;
    logic [1:0]       rr_osrc;
    logic             rr_ogrant;
    logic [3:0]       rr_occ;

    int n_chk;
    int n_fail;

    channel_merge_wrr #(
        .NUM_PORTS(NP), .REQ_WIDTH(RW), .LOG_DEPTH(LD), .BURST_MAX(4)
    ) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_grant(in_grant),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_grant(out_grant), .occupancy(occupancy)
    );

    channel_merge_wrr #(
        .NUM_PORTS(NP), .REQ_WIDTH(RW), .LOG_DEPTH(3), .BURST_MAX(1)
    ) u_rr (
        .clk(clk), .rst(rst),
        .in_valid(rr_valid), .in_data(rr_data), .in_grant(rr_grant),
        .out_valid(rr_ovalid), .out_data(rr_odata), .out_src(rr_osrc),
        .out_grant(rr_ogrant), .occupancy(rr_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] valid;
        logic       og;
        logic [3:0] exp_gnt;
        logic       exp_ov;
        logic [1:0] exp_src;
        logic [2:0] exp_occ;
    } vec_t;

    vec_t tbl [28];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [RW-1:0] exp_d;
        n_chk  = 0;
        n_fail = 0;

        tbl[0]  = '{4'b0101, 1'b1, 4'b0001, 1'b0, 2'd0, 3'd0};
        tbl[1]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 3'd1};
        tbl[2]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 3'd1};
        tbl[3]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 3'd1};
        tbl[4]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd0, 3'd1};
        tbl[5]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 3'd1};
        tbl[6]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 3'd1};
        tbl[7]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 3'd1};
        tbl[8]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd2, 3'd1};
        tbl[9]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 3'd1};
        tbl[10] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd0, 3'd1};
        tbl[11] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 3'd1};
        tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 3'd1};
        tbl[13] = '{4'b1001, 1'b1, 4'b0001, 1'b0, 2'd0, 3'd0};
        tbl[14] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 3'd1};
        tbl[15] = '{4'b0010, 1'b0, 4'b0010, 1'b0, 2'd0, 3'd0};
        tbl[16] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 3'd1};
        tbl[17] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 3'd2};
        tbl[18] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 3'd3};
        tbl[19] = '{4'b0010, 1'b0, 4'b0000, 1'b1, 2'd1, 3'd4};
        tbl[20] = '{4'b0010, 1'b1, 4'b0000, 1'b1, 2'd1, 3'd4};
        tbl[21] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 3'd3};
        tbl[22] = '{4'b0010, 1'b0, 4'b0000, 1'b1, 2'd1, 3'd4};
        tbl[23] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 3'd4};
        tbl[24] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 3'd3};
        tbl[25] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 3'd2};
        tbl[26] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 3'd1};
        tbl[27] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 3'd0};

        rst       = 1'b1;
        in_valid  = '0;
        out_grant = 1'b0;
        rr_valid  = '0;
        rr_ogrant = 1'b0;
        rr_data   = '0;
        for (int i = 0; i < NP; i++) in_data[i*RW +: RW] = RW'(16'h00A0 + i);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset occupancy", 32'(occupancy), 32'd0);
        chk("reset out_data", 32'(out_data), 32'd0);
        chk("reset out_src", 32'(out_src), 32'd0);
        chk("reset in_grant", 32'(in_grant), 32'd0);

        // Burst lock, lock break and fill/drain vectors
        for (int r = 0; r < 28; r++) begin
            in_valid  = tbl[r].valid;
            out_grant = tbl[r].og;
            #1;
            exp_d = tbl[r].exp_ov ? RW'(16'h00A0 + tbl[r].exp_src) : '0;
            chk($sformatf("vec%0d in_grant", r), 32'(in_grant), 32'(tbl[r].exp_gnt));
            chk($sformatf("vec%0d out_valid", r), 32'(out_valid), 32'(tbl[r].exp_ov));
            chk($sformatf("vec%0d out_src", r), 32'(out_src), 32'(tbl[r].exp_src));
            chk($sformatf("vec%0d occupancy", r), 32'(occupancy), 32'(tbl[r].exp_occ));
            chk($sformatf("vec%0d out_data", r), 32'(out_data), 32'(exp_d));
            @(negedge clk);
        end

        // Streaming through pointer wrap with occupancy held at 2
        for (int k = 0; k < 14; k++) begin
            in_valid = 4'b0100;
            in_data[2*RW +: RW] = RW'(16'h0100 + k);
            out_grant = (k >= 2);
            #1;
            chk($sformatf("wrap%0d in_grant", k), 32'(in_grant), 32'h4);
            chk($sformatf("wrap%0d occupancy", k), 32'(occupancy), (k >= 2) ? 32'd2 : 32'(k));
            if (k >= 1) begin
                chk($sformatf("wrap%0d out_data", k), 32'(out_data),
                    32'(16'h0100 + ((k >= 2) ? k - 2 : 0)));
            end
            @(negedge clk);
        end
        in_valid = '0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("drain%0d out_data", k), 32'(out_data), 32'(16'h0100 + 12 + k));
            chk($sformatf("drain%0d occupancy", k), 32'(occupancy), 32'(2 - k));
            @(negedge clk);
        end
        #1;
        chk("drained out_valid", 32'(out_valid), 32'd0);

        // Mid-stream reset with three entries queued
        @(negedge clk);
        out_grant = 1'b0;
        in_valid  = 4'b0010;
        repeat (3) @(negedge clk);
        #1;
        chk("pre-reset occupancy", 32'(occupancy), 32'd3);
        rst      = 1'b1;
        in_valid = '0;
        @(negedge clk);
        #1;
        chk("post-reset out_valid", 32'(out_valid), 32'd0);
        chk("post-reset occupancy", 32'(occupancy), 32'd0);
        chk("post-reset out_data", 32'(out_data), 32'd0);
        rst      = 1'b0;
        in_valid = 4'b1111;
        #1;
        chk("post-reset first grant", 32'(in_grant), 32'h1);

        // Pure round-robin instance: grants rotate 0,1,2,3,0
        in_valid  = '0;
        rr_valid  = 4'b1111;
        rr_ogrant = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("rr%0d grant", k), 32'(rr_grant), 32'(4'b0001 << (k % 4)));
            @(negedge clk);
        end
        rr_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
